// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, loadable instruction RAM and run controller
// feeding the decoder through a valid/ready slot with jump flush and faults.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     St,
    input  logic                     done,
    input  logic                     jump,
    input  logic [ADDR_W-1:0]        jump_target,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]       load_data,
    input  logic                     instr_ready,
    output logic                     instr_valid,
    output logic [INSTR_W-1:0]       instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     enable,
    output logic                     fault
);

    localparam int                SHIFT = $clog2(PC_STEP);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(PC_STEP - 1);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be at least 2");
    end
    if ((1 << SHIFT) != PC_STEP) begin : g_bad_step
        $error("fetch_unit: PC_STEP must be a power of two");
    end
    if ((START_PC & MASK) != '0) begin : g_bad_start
        $error("fetch_unit: START_PC must be PC_STEP aligned");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   idx;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [INSTR_W-1:0]  rd_data;
    logic                slot_free;
    logic                in_range;
    logic                misaligned;
    logic                load_ok;

    assign idx        = pc >> SHIFT;
    assign in_range   = idx < LIMIT;
    assign rd_data    = mem[idx[IDX_W-1:0]];
    assign slot_free  = !instr_valid || instr_ready;
    assign misaligned = |(jump_target & MASK);
    assign load_ok    = load_we && (state != RUN);

    // Loads and fetches never share an edge: one needs RUN, the other not.
    always_ff @(posedge CLK) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            pc          <= START_PC;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            enable      <= 1'b0;
            fault       <= 1'b0;
        end else if (St) begin
            state       <= RUN;
            pc          <= START_PC;
            instr_valid <= 1'b0;
            enable      <= 1'b1;
            fault       <= 1'b0;
        end else if (state == RUN) begin
            if (done) begin
                state       <= IDLE;
                instr_valid <= 1'b0;
                enable      <= 1'b0;
            end else if (jump) begin
                // Flush unconditionally; the new stream starts next cycle.
                instr_valid <= 1'b0;
                pc          <= jump_target;
                if (misaligned) begin
                    state  <= FAULT;
                    enable <= 1'b0;
                    fault  <= 1'b1;
                end
            end else if (slot_free) begin
                if (in_range) begin
                    instr_out   <= rd_data;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    pc          <= pc + STEP;
                end else begin
                    state       <= FAULT;
                    instr_valid <= 1'b0;
                    enable      <= 1'b0;
                    fault       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner
// sequences and a randomized run against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        St = 1'b0;
    logic        done = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        load_we = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        enable;
    logic        fault;

    fetch_unit dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .St(St),
        .done(done),
        .jump(jump),
        .jump_target(jump_target),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .instr_ready(instr_ready),
        .instr_valid(instr_valid),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .enable(enable),
        .fault(fault)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int passed = 0;
    logic [31:0] ram_img [32];

    typedef struct {
        bit          st;
        bit          dn;
        bit          jp;
        logic [31:0] tgt;
        bit          rdy;
        bit          v;
        logic [31:0] pc;
        logic [31:0] ins;
        bit          en;
        bit          f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit st, bit dn, bit jp, logic [31:0] tgt,
                                bit rdy, bit v, logic [31:0] pc,
                                logic [31:0] ins, bit en, bit f);
        vec_t r;
        r.st = st; r.dn = dn; r.jp = jp; r.tgt = tgt; r.rdy = rdy;
        r.v = v; r.pc = pc; r.ins = ins; r.en = en; r.f = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input bit v,
                             input logic [31:0] pc, input logic [31:0] ins,
                             input bit en, input bit f);
        check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
        check({tag, ".enable"}, {31'b0, enable}, {31'b0, en});
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, f});
        if (v) begin
            check({tag, ".pc"}, instr_pc, pc);
            check({tag, ".instr"}, instr_out, ins);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        St = 1'b0; done = 1'b0; jump = 1'b0; load_we = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_we = 1'b1; load_addr = 5'(a); load_data = d;
        step();
        load_we = 1'b0;
    endtask

    // Behavioural model state: 0 idle, 1 run, 2 fault.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_out;
    logic [31:0] m_ipc;
    bit          m_v;

    task automatic model_edge();
        if (load_we && m_mode != 1) ram_img[load_addr] = load_data;
        if (St) begin
            m_pc = 0; m_v = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            if (done) begin
                m_mode = 0; m_v = 0;
            end else if (jump) begin
                m_v = 0;
                if (jump_target % 4 != 0) m_mode = 2;
                else m_pc = jump_target;
            end else if (!m_v || instr_ready) begin
                if (m_pc / 4 < 32) begin
                    m_out = ram_img[m_pc / 4];
                    m_ipc = m_pc;
                    m_v = 1;
                    m_pc = m_pc + 4;
                end else begin
                    m_mode = 2; m_v = 0;
                end
            end
        end
    endtask

    logic [31:0] a0, a1, a2, a3, r4;

    initial begin
        #2;
        check_out("reset_hold", 0, 0, 0, 0, 0);
        check("reset_hold.instr", instr_out, 32'h0);
        check("reset_hold.pc", instr_pc, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        step();
        check_out("reset_rel", 0, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            ram_img[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0001;
            load(i, ram_img[i]);
        end
        a0 = ram_img[0]; a1 = ram_img[1]; a2 = ram_img[2];
        a3 = ram_img[3]; r4 = ram_img[4];

        // start, throughput, stall, jump flush, misaligned jump, St/done
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,   1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,0,a0,  1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,4,a1,  1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,8,a2,  1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,12,a3, 1,0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,   1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,0,a0,  1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,4,a1,  1,0));
        vecs.push_back(mk(0,0,0,0,0, 1,4,a1,  1,0));
        vecs.push_back(mk(0,0,0,0,0, 1,4,a1,  1,0));
        vecs.push_back(mk(0,0,0,0,0, 1,4,a1,  1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,8,a2,  1,0));
        vecs.push_back(mk(0,0,0,0,0, 1,8,a2,  1,0));
        vecs.push_back(mk(0,0,1,32'h10,0, 0,0,0, 1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,32'h10,r4, 1,0));
        vecs.push_back(mk(0,0,1,32'h12,1, 0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0,   0,1));
        vecs.push_back(mk(0,0,1,0,1, 0,0,0,   0,1));
        vecs.push_back(mk(0,1,0,0,1, 0,0,0,   0,1));
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,   1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,0,a0,  1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,4,a1,  1,0));
        vecs.push_back(mk(1,1,0,0,1, 0,0,0,   1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,0,a0,  1,0));
        vecs.push_back(mk(0,1,0,0,1, 0,0,0,   0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0,   0,0));
        vecs.push_back(mk(0,0,1,32'h40,1, 0,0,0, 0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,   1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,0,a0,  1,0));

        foreach (vecs[i]) begin
            St = vecs[i].st; done = vecs[i].dn; jump = vecs[i].jp;
            jump_target = vecs[i].tgt; instr_ready = vecs[i].rdy;
            step();
            clear_in();
            check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc,
                      vecs[i].ins, vecs[i].en, vecs[i].f);
        end

        // run off the end of the RAM
        instr_ready = 1'b1;
        St = 1'b1;
        step();
        clear_in();
        for (int i = 0; i < 32; i++) begin
            step();
            check_out($sformatf("seq%0d", i), 1, 32'(i) * 4, ram_img[i], 1, 0);
        end
        step();
        check_out("end_fault", 0, 0, 0, 0, 1);
        step();
        check_out("end_fault_hold", 0, 0, 0, 0, 1);
        St = 1'b1;
        step();
        clear_in();
        check_out("end_restart", 0, 0, 0, 1, 0);
        step();
        check_out("end_refetch", 1, 0, a0, 1, 0);

        // load in RUN ignored
        load_we = 1'b1; load_addr = 5'd0; load_data = 32'hDEAD_BEEF;
        step();
        clear_in();
        done = 1'b1;
        step();
        clear_in();
        check_out("idle_after_done", 0, 0, 0, 0, 0);
        St = 1'b1;
        step();
        clear_in();
        step();
        check_out("run_load_ignored", 1, 0, a0, 1, 0);

        // load and St on the same edge: write lands before the first fetch
        done = 1'b1;
        step();
        clear_in();
        load_we = 1'b1; load_addr = 5'd0; load_data = 32'h5A5A_1234;
        St = 1'b1;
        step();
        clear_in();
        step();
        check_out("load_with_st", 1, 0, 32'h5A5A_1234, 1, 0);
        done = 1'b1;
        step();
        clear_in();
        load(0, a0);

        // async reset mid-run
        St = 1'b1;
        step();
        clear_in();
        step();
        check_out("pre_reset", 1, 0, a0, 1, 0);
        #3 RST_n = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0, 0, 0);
        check("async_reset.instr", instr_out, 32'h0);
        check("async_reset.pc", instr_pc, 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        St = 1'b1;
        step();
        clear_in();
        step();
        check_out("post_reset_fetch", 1, 0, a0, 1, 0);

        // randomized run against the model
        RST_n = 1'b0;
        #2;
        RST_n = 1'b1;
        m_mode = 0; m_pc = 0; m_v = 0; m_out = 0; m_ipc = 0;
        @(negedge CLK);
        for (int c = 0; c < 800; c++) begin
            St = ($urandom_range(0, 29) == 0);
            done = ($urandom_range(0, 14) == 0);
            jump = ($urandom_range(0, 7) == 0);
            jump_target = ($urandom_range(0, 5) == 0) ?
                          32'($urandom_range(0, 160)) :
                          32'($urandom_range(0, 36)) * 4;
            instr_ready = ($urandom_range(0, 2) != 0);
            load_we = ($urandom_range(0, 3) == 0);
            load_addr = 5'($urandom);
            load_data = $urandom;
            model_edge();
            step();
            clear_in();
            check_out($sformatf("rnd%0d", c), m_v, m_ipc, m_out,
                      m_mode == 1, m_mode == 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
